// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: FSM state encodings, default
// timing parameters and internal field widths.
package sram_arbiter_pkg;

  localparam int unsigned RD_WAIT_DEFAULT  = 1;
  localparam int unsigned WR_PULSE_DEFAULT = 1;

  localparam int unsigned CNT_W   = 3;
  localparam int unsigned ADDR_W  = 20;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BE_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

endpackage

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single asynchronous SRAM.
// An instruction-fetch read port (if_*) and a data read/write port (d_*)
// share the SRAM; ties alternate, with the data port winning the first one.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   if_req/if_addr               fetch request, byte address
//   if_rdata/if_ack              fetched word, one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata/d_be   data request, direction, address, data, byte enables
//   d_rdata/d_ack                read word, one-cycle completion pulse
//   stall_req                    combinational pipeline stall request
//   sram_addr/sram_wdata/sram_wdata_oe/sram_rdata   SRAM word address and data bus
//   sram_ce_n/sram_oe_n/sram_we_n/sram_be_n         active-low SRAM strobes
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned RD_WAIT  = RD_WAIT_DEFAULT,
  parameter int unsigned WR_PULSE = WR_PULSE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        stall_req,
  output logic [19:0] sram_addr,
  output logic [31:0] sram_wdata,
  output logic        sram_wdata_oe,
  input  logic [31:0] sram_rdata,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [3:0]  sram_be_n
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_if_q, last_if_d;   // 1: last grant went to fetch
  logic                port_q, port_d;         // 1: data port owns the transaction
  logic                grant_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [BE_W-1:0]     be_q, be_d;

  logic                ce_n_d, oe_n_d, we_n_d, wdata_oe_d;
  logic [BE_W-1:0]     be_n_d;
  logic                if_ack_d, d_ack_d;
  logic                capture;

  // Word addressing only uses addr[21:2]
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:22], if_addr[1:0], d_addr[31:22], d_addr[1:0]};

  assign stall_req = (if_req & ~if_ack) | (d_req & ~d_ack);

  // Read data is sampled at the end of the last RD cycle
  assign capture = (state_q == ST_RD) && (cnt_q == '0);

  // Next state, grant, counter, and next-cycle strobe values
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_if_d  = last_if_q;
    port_d     = port_q;
    grant_d    = 1'b0;
    addr_d     = sram_addr;
    wdata_d    = sram_wdata;
    be_d       = be_q;
    ce_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;
    wdata_oe_d = 1'b0;
    be_n_d     = '1;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          // Data wins if it is alone or if fetch had the previous grant
          grant_d   = d_req & (~if_req | last_if_q);
          port_d    = grant_d;
          last_if_d = ~grant_d;
          if (grant_d) begin
            addr_d  = d_addr[21:2];
            wdata_d = d_wdata;
            be_d    = d_be;
          end else begin
            addr_d  = if_addr[21:2];
          end
          if (grant_d && d_we) begin
            state_d = ST_WR_SETUP;
          end else begin
            state_d = ST_RD;
            cnt_d   = CNT_W'(RD_WAIT);
          end
        end
      end
      ST_RD: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_WR_SETUP: begin
        state_d = ST_WR_PULSE;
        cnt_d   = CNT_W'(WR_PULSE - 1);
      end
      ST_WR_PULSE: begin
        if (cnt_q == '0) state_d = ST_WR_HOLD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_WR_HOLD: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Strobes are registered, so they are decoded from the next state
    case (state_d)
      ST_RD: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = '0;
      end
      ST_WR_SETUP, ST_WR_HOLD: begin
        ce_n_d     = 1'b0;
        wdata_oe_d = 1'b1;
        be_n_d     = ~be_d;
      end
      ST_WR_PULSE: begin
        ce_n_d     = 1'b0;
        we_n_d     = 1'b0;
        wdata_oe_d = 1'b1;
        be_n_d     = ~be_d;
      end
      ST_DONE: begin
        if_ack_d = ~port_d;
        d_ack_d  = port_d;
      end
      default: ;
    endcase
  end

  // State, counter and transaction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_if_q <= 1'b1;
      port_q    <= 1'b0;
      be_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_if_q <= last_if_d;
      port_q    <= port_d;
      be_q      <= be_d;
    end
  end

  // Registered SRAM interface and completion outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_addr     <= '0;
      sram_wdata    <= '0;
      sram_wdata_oe <= 1'b0;
      sram_ce_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
      sram_we_n     <= 1'b1;
      sram_be_n     <= '1;
      if_ack        <= 1'b0;
      d_ack         <= 1'b0;
      if_rdata      <= '0;
      d_rdata       <= '0;
    end else begin
      sram_addr     <= addr_d;
      sram_wdata    <= wdata_d;
      sram_wdata_oe <= wdata_oe_d;
      sram_ce_n     <= ce_n_d;
      sram_oe_n     <= oe_n_d;
      sram_we_n     <= we_n_d;
      sram_be_n     <= be_n_d;
      if_ack        <= if_ack_d;
      d_ack         <= d_ack_d;
      if (capture) begin
        if (port_q) d_rdata  <= sram_rdata;
        else        if_rdata <= sram_rdata;
      end
    end
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter RD_WAIT, default 1: number of extra SRAM read wait cycles (legal range 0..7).
REQ-002 Parameter WR_PULSE, default 1: width of the sram_we_n low pulse in cycles (legal range 1..7).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 if_req  in  1  instruction-fetch read request, held until if_ack.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_rdata  out  32  fetched word, valid while if_ack=1.
REQ-008 if_ack  out  1  one-cycle fetch completion pulse.
REQ-009 d_req  in  1  data request from the memory stage, held until d_ack.
REQ-010 d_we  in  1  1=write, 0=read.
REQ-011 d_addr  in  32  data byte address.
REQ-012 d_wdata  in  32  write data.
REQ-013 d_be  in  4  active-high byte enables for writes.
REQ-014 d_rdata  out  32  read word, valid while d_ack=1.
REQ-015 d_ack  out  1  one-cycle data completion pulse.
REQ-016 stall_req  out  1  pipeline stall request to the pipeline controller.
REQ-017 sram_addr  out  20  SRAM word address.
REQ-018 sram_wdata  out  32  SRAM write data.
REQ-019 sram_wdata_oe  out  1  tristate enable for sram_wdata.
REQ-020 sram_rdata  in  32  SRAM read data.
REQ-021 sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.
REQ-022 sram_be_n  out  4  active-low SRAM byte enables.

Function
REQ-023 The FSM SHALL use the states IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD and DONE.
REQ-024 In IDLE, a pending request SHALL be granted and its address, write data, byte enables and direction SHALL be registered at the clock edge.
REQ-025 When only one port requests, that port SHALL be granted.
REQ-026 When both ports request, the port not granted last SHALL be granted (alternating priority).
REQ-027 The last-grant flag SHALL be initialised to IF at reset, so that the data port wins the first tie.
REQ-028 sram_addr SHALL equal registered addr[21:2]; addr[31:22] and addr[1:0] SHALL be ignored.
REQ-029 Read path: IDLE->RD, which lasts RD_WAIT+1 cycles with ce_n=0, oe_n=0, be_n=0000.
REQ-030 sram_rdata SHALL be captured at the end of the last RD cycle, followed by RD->DONE.
REQ-031 Write path: WR_SETUP for 1 cycle (ce_n=0, we_n=1, wdata_oe=1), then WR_PULSE for WR_PULSE cycles (we_n=0), then WR_HOLD for 1 cycle (we_n=1, wdata_oe=1), then DONE.
REQ-032 During writes, sram_be_n SHALL equal ~be and oe_n SHALL equal 1.
REQ-033 sram_wdata_oe and ~sram_oe_n SHALL never be high in the same cycle.
REQ-034 In DONE, the ack of the granted port SHALL be 1 for exactly one cycle with its rdata valid; all strobes SHALL be inactive; DONE->IDLE.
REQ-035 Read latency: with the request first seen in IDLE at cycle 0, ack SHALL occur at cycle RD_WAIT+2 (3 at default).
REQ-036 Write latency: ack SHALL occur at cycle WR_PULSE+3 (4 at default).
REQ-037 A new grant SHALL NOT be made in DONE; the earliest next grant is in the following IDLE cycle.
REQ-038 rdata outputs SHALL hold their last captured value after ack.
REQ-039 stall_req SHALL be combinational, equal to (if_req & ~if_ack) | (d_req & ~d_ack).
REQ-040 If req drops before ack, the transaction SHALL still complete and the ack SHALL still be issued.
REQ-041 A d_we=1 request with d_be=0000 SHALL run the full write sequence with sram_be_n=1111.
REQ-042 A single internal wait counter of 3 bits SHALL time RD and WR_PULSE.

Reset
REQ-043 While rst=1 at a clock edge, the block SHALL enter: state IDLE, counter 0, last-grant IF.
REQ-044 While rst=1 at a clock edge, the block SHALL drive: ce_n=oe_n=we_n=1, be_n=1111, wdata_oe=0, sram_addr=0, sram_wdata=0, both acks 0, both rdata 0.
REQ-045 Reset mid-transaction SHALL abandon the transaction and produce no ack; we_n SHALL be 1 from the first reset cycle.

Structure
REQ-046 FSM state encodings and the default RD_WAIT/WR_PULSE values SHALL reside in the shared include/package.
REQ-047 There SHALL be no sub-module; the grant logic and the counter are inline.

Verification
REQ-048 Read: d_req=1, d_we=0, d_addr=0x0000_0010, sram_rdata=0xDEADBEEF -> sram_addr=0x00004, d_ack at cycle 3, d_rdata=0xDEADBEEF.
REQ-049 Write: d_we=1, d_addr=0x0000_0008, d_wdata=0x12345678, d_be=0011 -> sram_addr=0x00002, be_n=1100, we_n low exactly in cycle 2, d_ack at cycle 4.
REQ-050 Tie: if_req and d_req both asserted from reset -> data served first; fetch ack 4 cycles after d_ack (RD_WAIT=1); d_req re-raised immediately still loses to IF.
REQ-051 Reset in WR_PULSE -> we_n=1 and ack=0 next cycle, FSM in IDLE.
REQ-052 RD_WAIT=0, WR_PULSE=3 -> read ack at cycle 2; write we_n low for 3 cycles and ack at cycle 6; stall_req high every cycle until the ack.
